// File: rtl/hamming_fsk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hamming_fsk_pkg
// Description : Shared types and constants for the Hamming/FSK transmit path.
// Revision    : 1.0 - initial release
// ============================================================================
package hamming_fsk_pkg;

  // Codeword and data widths for Hamming(7,4)
  localparam int CODE_W = 7;
  localparam int DATA_W = 4;

  // Clock cycles in one period of the slow FSK carrier; a coded bit must
  // span a whole number of these so the encoder emits complete cycles
  localparam int CARRIER_SLOW_CLKS = 16;

  // Serializer control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/hamming74_enc.sv
`default_nettype none
// ============================================================================
// Module      : hamming74_enc
// Description : Combinational Hamming(7,4) encoder. Output bit [6] is
//               codeword position 1 (first transmitted), bit [0] is position 7.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming74_enc
  import hamming_fsk_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [CODE_W-1:0] code
);

  logic w_d1, w_d2, w_d3, w_d4;
  logic w_p1, w_p2, w_p3;

  assign w_d1 = data[3];
  assign w_d2 = data[2];
  assign w_d3 = data[1];
  assign w_d4 = data[0];

  // Each parity bit covers the three data bits sharing its position bit
  assign w_p1 = w_d1 ^ w_d2 ^ w_d4;
  assign w_p2 = w_d1 ^ w_d3 ^ w_d4;
  assign w_p3 = w_d2 ^ w_d3 ^ w_d4;

  // Positions 1..7 = p1 p2 d1 p3 d2 d3 d4, position 1 in the MSB
  assign code = {w_p1, w_p2, w_d1, w_p3, w_d2, w_d3, w_d4};

endmodule
`default_nettype wire

// File: rtl/hamming_serializer.sv
`default_nettype none
// ============================================================================
// Module      : hamming_serializer
// Description : Accepts a nibble over valid/ready, Hamming(7,4)-encodes it and
//               shifts the codeword out on codein, one bit per BIT_CLKS cycles,
//               with sending framing the 7 bits and an optional idle gap after.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_serializer
  import hamming_fsk_pkg::*;
#(
  parameter int BIT_CLKS = 16,
  parameter int GAP_CLKS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              codein,
  output logic              sending,
  output logic              frame_done
);

  localparam int CLK_W = $clog2(BIT_CLKS);
  localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  localparam logic [CLK_W-1:0] C_BIT_LAST  = CLK_W'(BIT_CLKS - 1);
  localparam logic [GAP_W-1:0] C_GAP_LAST  = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
  localparam logic [2:0]       C_LAST_SLOT = 3'(CODE_W - 1);

  // A coded bit must last a whole number of slow-carrier periods
  generate
    if ((BIT_CLKS < CARRIER_SLOW_CLKS) || ((BIT_CLKS % CARRIER_SLOW_CLKS) != 0)) begin : g_bad_bit_clks
      $error("hamming_serializer: BIT_CLKS must be a non-zero multiple of %0d", CARRIER_SLOW_CLKS);
    end
  endgenerate

  state_t            r_state,   w_state_nxt;
  logic [CODE_W-1:0] r_shift,   w_shift_nxt;
  logic [CLK_W-1:0]  r_clk_cnt, w_clk_cnt_nxt;
  logic [2:0]        r_bit_cnt, w_bit_cnt_nxt;
  logic [GAP_W-1:0]  r_gap_cnt, w_gap_cnt_nxt;
  logic [CODE_W-1:0] w_code;
  logic              w_accept;

  hamming74_enc u_enc (
    .data (data_in),
    .code (w_code)
  );

  assign w_accept = data_valid && data_ready;

  // Next-state, counter and shift-register logic
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_clk_cnt_nxt = r_clk_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt   = SEND;
          w_shift_nxt   = w_code;
          w_clk_cnt_nxt = '0;
          w_bit_cnt_nxt = '0;
        end
      end
      SEND: begin
        if (r_clk_cnt == C_BIT_LAST) begin
          w_clk_cnt_nxt = '0;
          if (r_bit_cnt == C_LAST_SLOT) begin
            // Last bit done: always leave SEND so sending drops for a cycle
            w_bit_cnt_nxt = '0;
            w_shift_nxt   = '0;
            w_gap_cnt_nxt = '0;
            w_state_nxt   = (GAP_CLKS == 0) ? IDLE : GAP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            w_shift_nxt   = {r_shift[CODE_W-2:0], 1'b0};
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + CLK_W'(1);
        end
      end
      GAP: begin
        if (r_gap_cnt == C_GAP_LAST) begin
          w_gap_cnt_nxt = '0;
          w_state_nxt   = IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_clk_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_gap_cnt  <= '0;
      data_ready <= 1'b0;
      codein     <= 1'b0;
      sending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_clk_cnt  <= w_clk_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      data_ready <= (w_state_nxt == IDLE);
      sending    <= (w_state_nxt == SEND);
      codein     <= (w_state_nxt == SEND) && w_shift_nxt[CODE_W-1];
      frame_done <= (w_state_nxt == SEND) && (w_bit_cnt_nxt == C_LAST_SLOT)
                    && (w_clk_cnt_nxt == C_BIT_LAST);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hamming_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hamming_serializer
// Description : Self-checking bench for hamming_serializer. Three instances
//               cover default timing, zero gap and a 32-clock bit period.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming_serializer;

  localparam int BC [3] = '{16, 16, 32};
  localparam int GC [3] = '{16, 0, 16};

  logic       clk = 1'b0;
  logic [2:0] rst_v;
  logic [2:0] valid_v;
  logic [3:0] din_v [3];
  logic [2:0] rdy_v, code_v, send_v, fd_v;

  int checks = 0;
  int errors = 0;

  // {data_ready, sending, codein, frame_done} per cycle
  logic [3:0] obs_q [$];
  logic [3:0] exp_q [$];

  always #5 clk = ~clk;

  hamming_serializer #(.BIT_CLKS(16), .GAP_CLKS(16)) u_dut_def (
    .clk(clk), .reset(rst_v[0]), .data_in(din_v[0]), .data_valid(valid_v[0]),
    .data_ready(rdy_v[0]), .codein(code_v[0]), .sending(send_v[0]), .frame_done(fd_v[0]));

  hamming_serializer #(.BIT_CLKS(16), .GAP_CLKS(0)) u_dut_nogap (
    .clk(clk), .reset(rst_v[1]), .data_in(din_v[1]), .data_valid(valid_v[1]),
    .data_ready(rdy_v[1]), .codein(code_v[1]), .sending(send_v[1]), .frame_done(fd_v[1]));

  hamming_serializer #(.BIT_CLKS(32), .GAP_CLKS(16)) u_dut_wide (
    .clk(clk), .reset(rst_v[2]), .data_in(din_v[2]), .data_valid(valid_v[2]),
    .data_ready(rdy_v[2]), .codein(code_v[2]), .sending(send_v[2]), .frame_done(fd_v[2]));

  // Reference encoder from the positional definition of Hamming codes:
  // parity at position 2^k covers every position whose index has bit k set.
  function automatic logic [6:0] ref_encode(input logic [3:0] d);
    logic pos [8];
    logic [6:0] cw;
    for (int i = 0; i < 8; i++) pos[i] = 1'b0;
    pos[3] = d[3];
    pos[5] = d[2];
    pos[6] = d[1];
    pos[7] = d[0];
    for (int k = 0; k < 3; k++) begin
      logic p;
      p = 1'b0;
      for (int i = 1; i < 8; i++)
        if (((i >> k) & 1) == 1 && i != (1 << k)) p = p ^ pos[i];
      pos[1 << k] = p;
    end
    for (int i = 1; i < 8; i++) cw[7 - i] = pos[i];
    return cw;
  endfunction

  // Expected timeline: cycle 1 follows the accept edge
  task automatic build_expected(input logic [3:0] d, input int bc, input int gc, input int n);
    logic [6:0] cw;
    cw = ref_encode(d);
    exp_q.delete();
    for (int cyc = 1; cyc <= n; cyc++) begin
      if (cyc <= 7 * bc)
        exp_q.push_back({1'b0, 1'b1, cw[6 - (cyc - 1) / bc], (cyc == 7 * bc)});
      else if (cyc <= 7 * bc + gc)
        exp_q.push_back(4'b0000);
      else
        exp_q.push_back(4'b1000);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record n cycles of outputs; optionally toggle data_valid/data_in in cycles 5..40
  task automatic capture(input int id, input int n, input bit noise);
    obs_q.delete();
    for (int cyc = 1; cyc <= n; cyc++) begin
      obs_q.push_back({rdy_v[id], send_v[id], code_v[id], fd_v[id]});
      if (noise && cyc >= 5 && cyc <= 40) begin
        valid_v[id] = 1'($urandom_range(0, 1));
        din_v[id]   = 4'($urandom);
      end else if (noise && cyc == 41) begin
        valid_v[id] = 1'b0;
      end
      tick();
    end
  endtask

  task automatic accept(input int id, input logic [3:0] d, input bit hold);
    din_v[id]   = d;
    valid_v[id] = 1'b1;
    tick();
    if (!hold) valid_v[id] = 1'b0;
  endtask

  task automatic test_reset();
    rst_v = 3'b111;
    tick();
    tick();
    for (int id = 0; id < 3; id++) begin
      checks++;
      if ({rdy_v[id], send_v[id], code_v[id], fd_v[id]} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold dut%0d: got %b expected 0000", id,
                 {rdy_v[id], send_v[id], code_v[id], fd_v[id]});
      end
    end
    rst_v = 3'b000;
    tick();
    for (int id = 0; id < 3; id++) begin
      checks++;
      if ({rdy_v[id], send_v[id], code_v[id], fd_v[id]} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_release dut%0d: got %b expected 1000", id,
                 {rdy_v[id], send_v[id], code_v[id], fd_v[id]});
      end
    end
  endtask

  task automatic test_known_1011();
    accept(0, 4'b1011, 1'b0);
    capture(0, 7 * 16 + 16 + 1, 1'b0);
    build_expected(4'b1011, 16, 16, 7 * 16 + 16 + 1);
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL known_1011 cycle %0d: got rdy/send/code/done=%b expected %b",
                 i + 1, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    accept(1, 4'b0001, 1'b1);
    din_v[1] = 4'b1111;
    capture(1, 113, 1'b0);
    valid_v[1] = 1'b0;
    build_expected(4'b0001, 16, 0, 113);
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_first cycle %0d: got %b expected %b", i + 1, obs_q[i], exp_q[i]);
      end
    end
    capture(1, 113, 1'b0);
    build_expected(4'b1111, 16, 0, 113);
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_second cycle %0d: got %b expected %b", i + 114, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_ignored_valid();
    logic [3:0] d;
    d = 4'($urandom);
    accept(0, d, 1'b0);
    capture(0, 7 * 16 + 16 + 1 + 10, 1'b1);
    build_expected(d, 16, 16, 7 * 16 + 16 + 1 + 10);
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ignored_valid d=%h cycle %0d: got %b expected %b", d, i + 1, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] d;
    d = 4'($urandom);
    accept(0, d, 1'b0);
    capture(0, 49, 1'b0);
    build_expected(d, 16, 16, 49);
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL pre_reset cycle %0d: got %b expected %b", i + 1, obs_q[i], exp_q[i]);
      end
    end
    rst_v[0] = 1'b1;
    tick();
    checks++;
    if ({rdy_v[0], send_v[0], code_v[0], fd_v[0]} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset cycle 51: got %b expected 0000", {rdy_v[0], send_v[0], code_v[0], fd_v[0]});
    end
    rst_v[0] = 1'b0;
    tick();
    checks++;
    if ({rdy_v[0], send_v[0], code_v[0], fd_v[0]} !== 4'b1000) begin
      errors++;
      $display("FAIL post_reset cycle 52: got %b expected 1000", {rdy_v[0], send_v[0], code_v[0], fd_v[0]});
    end
    d = 4'($urandom);
    accept(0, d, 1'b0);
    capture(0, 129, 1'b0);
    build_expected(d, 16, 16, 129);
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL after_reset_frame d=%h cycle %0d: got %b expected %b", d, i + 1, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_wide_zero();
    accept(2, 4'b0000, 1'b0);
    capture(2, 7 * 32 + 16 + 1, 1'b0);
    build_expected(4'b0000, 32, 16, 7 * 32 + 16 + 1);
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL wide_zero cycle %0d: got %b expected %b", i + 1, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random_frames();
    for (int k = 0; k < 8; k++) begin
      int id;
      int n;
      logic [3:0] d;
      id = k % 2;
      d  = 4'($urandom);
      n  = 7 * BC[id] + GC[id] + 1;
      checks++;
      if (rdy_v[id] !== 1'b1) begin
        errors++;
        $display("FAIL random_ready dut%0d: got %b expected 1", id, rdy_v[id]);
      end
      accept(id, d, 1'b0);
      din_v[id] = 4'($urandom);
      capture(id, n, 1'b0);
      build_expected(d, BC[id], GC[id], n);
      for (int i = 0; i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL random dut%0d d=%h cycle %0d: got %b expected %b", id, d, i + 1, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    rst_v   = 3'b111;
    valid_v = 3'b000;
    for (int i = 0; i < 3; i++) din_v[i] = 4'b0000;
    test_reset();
    test_known_1011();
    test_back_to_back();
    test_ignored_valid();
    test_reset_mid_frame();
    test_wide_zero();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
